// File: rtl/uart_reg_master.sv
// Host-side initiator for the UART register-access protocol: turns one read or
// write request into command bytes on a byte-level UART and returns one response.
module uart_reg_master #(
  parameter logic [7:0]  CMD_WR         = 8'h57,
  parameter logic [7:0]  CMD_RD         = 8'h52,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_we_i,
  input  logic [7:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       rsp_err_o,
  output logic       busy_o,
  output logic [7:0] tx_data_o,
  output logic       tx_wr_o,
  input  logic       tx_done_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_i
);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_TX,
    WAIT_RX,
    RESP
  } state_t;

  localparam logic [23:0] CNT_LAST = 24'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [1:0]  idx;
  logic [23:0] cnt;
  logic        we_q;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        accept;
  logic        last_byte;
  logic        expired;

  function automatic logic [7:0] frame_byte(input logic [1:0] i, input logic we,
                                            input logic [7:0] addr, input logic [7:0] wdata);
    case (i)
      2'd0:    frame_byte = we ? CMD_WR : CMD_RD;
      2'd1:    frame_byte = addr;
      default: frame_byte = wdata;
    endcase
  endfunction

  // Ready and busy are decoded from state so the accept cycle itself reads busy.
  assign req_ready_o = (state == IDLE) && !sys_rst;
  assign accept      = req_valid_i && req_ready_o;
  assign busy_o      = (state != IDLE) || accept;
  assign last_byte   = we_q ? (idx == 2'd2) : (idx == 2'd1);
  assign expired     = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
    end
  end

  // Outputs are registered on entry to the state that owns them (SEND, RESP).
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      idx         <= 2'd0;
      cnt         <= 24'd0;
      tx_wr_o     <= 1'b0;
      tx_data_o   <= 8'd0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= 8'd0;
    end else begin
      tx_wr_o     <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= 8'd0;
      case (state)
        IDLE: begin
          if (accept) begin
            idx       <= 2'd0;
            tx_wr_o   <= 1'b1;
            tx_data_o <= frame_byte(2'd0, req_we_i, req_addr_i, req_wdata_i);
            state     <= SEND;
          end
        end
        SEND: begin
          cnt   <= 24'd0;
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done_i) begin
            if (!last_byte) begin
              idx       <= 2'(idx + 2'd1);
              tx_wr_o   <= 1'b1;
              tx_data_o <= frame_byte(2'(idx + 2'd1), we_q, addr_q, wdata_q);
              state     <= SEND;
            end else if (we_q) begin
              rsp_valid_o <= 1'b1;
              state       <= RESP;
            end else begin
              cnt   <= 24'd0;
              state <= WAIT_RX;
            end
          end else if (expired) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        WAIT_RX: begin
          if (rx_done_i) begin
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= rx_data_i;
            state       <= RESP;
          end else if (expired) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
